mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core, debug/loader and single-port RAM signal bundle for mem_arbiter
//
// Groups the three ports of the arbiter.
//   slave  : arbiter side (requests in, grants/data out, RAM driven out)
//   master : environment side (core, debug agent and RAM model)
// Core   : c_R_en, c_W_en, c_RW_type[2:0], c_addr[31:0], c_wdata[31:0] -> c_rdata[31:0], c_stall
// Debug  : d_req, d_we, d_RW_type[2:0], d_addr[31:0], d_wdata[31:0]  -> d_gnt, d_rvalid, d_rdata[31:0]
// RAM    : m_R_en, m_W_en, m_RW_type[2:0], m_addr[31:0], m_wdata[31:0] <- m_rdata[31:0]
interface mem_arbiter_if;
  logic        c_R_en;
  logic        c_W_en;
  logic [2:0]  c_RW_type;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_stall;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_RW_type;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_R_en;
  logic        m_W_en;
  logic [2:0]  m_RW_type;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  c_R_en, c_W_en, c_RW_type, c_addr, c_wdata,
    output c_rdata, c_stall,
    input  d_req, d_we, d_RW_type, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_R_en, m_W_en, m_RW_type, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_R_en, c_W_en, c_RW_type, c_addr, c_wdata,
    input  c_rdata, c_stall,
    output d_req, d_we, d_RW_type, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_R_en, m_W_en, m_RW_type, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (core, debug/loader) arbiter for one single-port RAM
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (core, debug and RAM signal groups)
// Optional feature macro: MEM_ARBITER_RR_EN
//   defined   -> conflicts resolved round-robin (requester not granted most recently wins)
//   undefined -> conflicts resolved with fixed core priority (debug may starve)
// New RAM accesses are issued only in IDLE; reads spend one extra cycle
// (RD_CORE / RD_DBG) while the RAM returns data.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_CORE, RD_DBG} state_t;

  state_t      state;
  logic [31:0] d_rdata_q;
  logic        core_req;
  logic        dbg_req;
  logic        in_idle;
  logic        core_pri;
  logic        core_win;
  logic        dbg_win;

`ifdef MEM_ARBITER_RR_EN
  // 1 when the debug port was granted most recently; core gets the next conflict.
  logic last_dbg;
  assign core_pri = last_dbg;
`else
  assign core_pri = 1'b1;
`endif

  assign core_req = bus.c_R_en | bus.c_W_en;
  assign dbg_req  = bus.d_req;
  // Gating with rst_n keeps every grant and RAM strobe low while reset is held.
  assign in_idle  = rst_n && (state == IDLE);
  assign core_win = in_idle && core_req && (!dbg_req || core_pri);
  assign dbg_win  = in_idle && dbg_req && !core_win;

  always_comb begin
    bus.m_R_en    = 1'b0;
    bus.m_W_en    = 1'b0;
    bus.m_RW_type = 3'd0;
    bus.m_addr    = 32'd0;
    bus.m_wdata   = 32'd0;
    if (core_win) begin
      bus.m_R_en    = bus.c_R_en;
      bus.m_W_en    = bus.c_W_en;
      bus.m_RW_type = bus.c_RW_type;
      bus.m_addr    = bus.c_addr;
      bus.m_wdata   = bus.c_wdata;
    end else if (dbg_win) begin
      bus.m_R_en    = !bus.d_we;
      bus.m_W_en    = bus.d_we;
      bus.m_RW_type = bus.d_RW_type;
      bus.m_addr    = bus.d_addr;
      bus.m_wdata   = bus.d_wdata;
    end
  end

  always_comb begin
    bus.d_gnt    = dbg_win;
    bus.d_rvalid = rst_n && (state == RD_DBG);
    // Read data is presented with d_rvalid and then held by the register.
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : d_rdata_q;
    bus.c_rdata  = (rst_n && (state == RD_CORE)) ? bus.m_rdata : 32'd0;
    // The core completes on a granted write or in its read-return cycle;
    // any other cycle with a core request present is a stall.
    bus.c_stall  = rst_n && core_req &&
                   !((core_win && bus.c_W_en) || (state == RD_CORE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_rdata_q <= 32'd0;
`ifdef MEM_ARBITER_RR_EN
      last_dbg  <= 1'b1;
`endif
    end else begin
`ifdef MEM_ARBITER_RR_EN
      if (core_win)
        last_dbg <= 1'b0;
      else if (dbg_win)
        last_dbg <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (core_win && bus.c_R_en)
            state <= RD_CORE;
          else if (dbg_win && !bus.d_we)
            state <= RD_DBG;
        end
        RD_CORE: state <= IDLE;
        RD_DBG: begin
          d_rdata_q <= bus.m_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
